// File: rtl/result_acc_ctrl_pkg.sv
// Shared types and constants for the result accumulator sequencer.
// Holds the FSM state encoding, the Control-line levels and the default widths.
package result_ctrl_pkg;

    localparam int LEN_W_DEF  = 8;
    localparam int TILE_W_DEF = 10;

    // Levels of the shared accumulator Control line.
    localparam logic ACC_CTRL_FEEDBACK = 1'b1;
    localparam logic ACC_CTRL_EMIT     = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FIRST,
        ST_ACC,
        ST_HOLD,
        ST_WAIT_OUT
    } state_e;

endpackage

// File: rtl/result_acc_ctrl_if.sv
// Beat stream, accumulator control and finished-tile handshake of the sequencer.
// The sequencer takes the master side; the PE array / output writer take the slave side.
interface result_acc_ctrl_if #(
    parameter int TILE_W = 10
);
    logic              in_valid;
    logic              in_ready;
    logic              acc_in_en;
    logic              acc_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [TILE_W-1:0] out_tile_idx;
    logic              out_last;

    modport master (
        input  in_valid,
        input  out_ready,
        output in_ready,
        output acc_in_en,
        output acc_ctrl,
        output out_valid,
        output out_tile_idx,
        output out_last
    );

    modport slave (
        output in_valid,
        output out_ready,
        input  in_ready,
        input  acc_in_en,
        input  acc_ctrl,
        input  out_valid,
        input  out_tile_idx,
        input  out_last
    );
endinterface

// File: rtl/result_out_reg.sv
// Holding register for the finished tile presented to the output writer.
// A load wins over the consume-clear, so back-to-back tiles keep out_valid high.
module result_out_reg #(
    parameter int TILE_W = 10
) (
    input  logic              Clk,
    input  logic              rst,
    input  logic              abort,
    input  logic              load,
    input  logic [TILE_W-1:0] load_idx,
    input  logic              load_last,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [TILE_W-1:0] out_tile_idx,
    output logic              out_last
);

    // NOTE: sequential state is always written with non-blocking assignments so
    // every register samples the pre-edge values of its inputs.
    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_tile_idx <= '0;
            out_last     <= 1'b0;
        end else if (abort) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_valid    <= 1'b1;
            out_tile_idx <= load_idx;
            out_last     <= load_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/result_acc_ctrl.sv
// Sequencer for the four-lane result accumulator group: counts partial-sum beats per
// tile, drives the shared Control line and hands finished tiles to the output writer.
module result_acc_ctrl
    import result_ctrl_pkg::*;
#(
    parameter int LEN_W  = LEN_W_DEF,
    parameter int TILE_W = TILE_W_DEF
) (
    input  logic              Clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [LEN_W-1:0]  cfg_acc_len,
    input  logic [TILE_W-1:0] cfg_num_tiles,
    result_acc_ctrl_if.master bus,
    output logic              busy,
    output logic              done,
    output logic              cfg_err
);

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  len_q;
    logic [TILE_W-1:0] num_q;
    logic [LEN_W-1:0]  beat_q, beat_d;
    logic [TILE_W-1:0] tile_q, tile_d;

    logic              in_ready;
    logic              acc_ctrl;
    logic              load;
    logic              latch_cfg;
    logic              done_d;
    logic              cfg_err_d;
    logic              emit_ok;
    logic              last_tile;

    logic              out_valid;
    logic [TILE_W-1:0] out_tile_idx;
    logic              out_last;

    assign emit_ok   = !out_valid || bus.out_ready;
    assign last_tile = (tile_q == num_q - TILE_W'(1));

    // NOTE: every variable written here gets a default first; a path that skips
    // an assignment would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        tile_d    = tile_q;
        in_ready  = 1'b0;
        acc_ctrl  = ACC_CTRL_EMIT;
        load      = 1'b0;
        latch_cfg = 1'b0;
        done_d    = 1'b0;
        cfg_err_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (cfg_acc_len == '0 || cfg_num_tiles == '0) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        latch_cfg = 1'b1;
                        beat_d    = '0;
                        tile_d    = '0;
                        state_d   = ST_FIRST;
                    end
                end
            end

            ST_FIRST: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    beat_d  = LEN_W'(1);
                    state_d = (len_q == LEN_W'(1)) ? ST_HOLD : ST_ACC;
                end
            end

            ST_ACC: begin
                acc_ctrl = ACC_CTRL_FEEDBACK;
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    beat_d = beat_q + LEN_W'(1);
                    if (beat_q == len_q - LEN_W'(1)) state_d = ST_HOLD;
                end
            end

            ST_HOLD: begin
                if (!emit_ok) begin
                    // Inputs are gated to zero, so feedback keeps the sum intact.
                    acc_ctrl = ACC_CTRL_FEEDBACK;
                end else begin
                    load = 1'b1;
                    if (last_tile) begin
                        state_d = ST_WAIT_OUT;
                    end else begin
                        tile_d   = tile_q + TILE_W'(1);
                        in_ready = 1'b1;
                        if (bus.in_valid) begin
                            beat_d  = LEN_W'(1);
                            state_d = (len_q == LEN_W'(1)) ? ST_HOLD : ST_ACC;
                        end else begin
                            beat_d  = '0;
                            state_d = ST_FIRST;
                        end
                    end
                end
            end

            ST_WAIT_OUT: begin
                if (out_valid && bus.out_ready) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        if (abort) begin
            state_d   = ST_IDLE;
            load      = 1'b0;
            latch_cfg = 1'b0;
            done_d    = 1'b0;
            cfg_err_d = 1'b0;
        end
    end

    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            num_q   <= '0;
            beat_q  <= '0;
            tile_q  <= '0;
            done    <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            tile_q  <= tile_d;
            done    <= done_d;
            cfg_err <= cfg_err_d;
            if (latch_cfg) begin
                len_q <= cfg_acc_len;
                num_q <= cfg_num_tiles;
            end
        end
    end

    result_out_reg #(
        .TILE_W (TILE_W)
    ) u_out_reg (
        .Clk          (Clk),
        .rst          (rst),
        .abort        (abort),
        .load         (load),
        .load_idx     (tile_q),
        .load_last    (last_tile),
        .out_ready    (bus.out_ready),
        .out_valid    (out_valid),
        .out_tile_idx (out_tile_idx),
        .out_last     (out_last)
    );

    assign busy             = (state_q != ST_IDLE);
    assign bus.in_ready     = in_ready;
    assign bus.acc_in_en    = bus.in_valid && in_ready;
    assign bus.acc_ctrl     = acc_ctrl;
    assign bus.out_valid    = out_valid;
    assign bus.out_tile_idx = out_tile_idx;
    assign bus.out_last     = out_last;

endmodule
